// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - shared load-stream definitions: magic byte and FSM state encodings
package ram_loader_pkg;

  // First byte of every load stream
  localparam logic [7:0] MAGIC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR0 = 3'd1,
    ST_ADDR1 = 3'd2,
    ST_CNT0  = 3'd3,
    ST_CNT1  = 3'd4,
    ST_DATA  = 3'd5,
    ST_WRITE = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

endpackage

// File: rtl/_RAM_32bit_16aline.sv
// rtl/_RAM_32bit_16aline.sv - 64K x 32 RAM, one synchronous write port, one combinational read port
module _RAM_32bit_16aline (
  input  logic        clk,
  input  logic [15:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        wr_en,
  input  logic [15:0] rd_addr,
  output logic [31:0] rd_data
);

  logic [31:0] mem_q [0:65535];

  // Write port: one word per strobed cycle
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - byte-stream loader: magic, start address, word count, then little-endian words to RAM
import ram_loader_pkg::*;

module ram_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_write,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           count_q, count_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  error_q, error_d;
  logic [15:0]           count_full;

  // Full 16-bit count as it will be once the high byte lands in CNT1
  assign count_full = {in_byte, count_q[7:0]};

  // Next-state, datapath updates and per-state outputs
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    error_d    = 1'b0;
    in_ready   = 1'b0;
    ram_write  = 1'b0;
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_byte == MAGIC_BYTE) begin
            state_d    = ST_ADDR0;
            byte_cnt_d = 2'd0;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      ST_ADDR0: begin
        in_ready = 1'b1;
        if (in_valid) begin
          addr_d[7:0] = in_byte;
          state_d     = ST_ADDR1;
        end
      end

      ST_ADDR1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          addr_d  = ADDR_WIDTH'({in_byte, addr_q[7:0]});
          state_d = ST_CNT0;
        end
      end

      ST_CNT0: begin
        in_ready = 1'b1;
        if (in_valid) begin
          count_d[7:0] = in_byte;
          state_d      = ST_CNT1;
        end
      end

      ST_CNT1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          count_d    = count_full;
          byte_cnt_d = 2'd0;
          state_d    = (count_full == 16'd0) ? ST_DONE : ST_DATA;
        end
      end

      ST_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d[{byte_cnt_q, 3'b000} +: 8] = in_byte;
          byte_cnt_d                        = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        // A reset landing on this cycle must not let the RAM commit the word
        ram_write = ~reset;
        addr_d    = addr_q + ADDR_WIDTH'(1);
        count_d   = count_q - 16'd1;
        state_d   = (count_q == 16'd1) ? ST_DONE : ST_DATA;
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      byte_cnt_q <= '0;
      data_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      error_q    <= error_d;
    end
  end

  assign ram_address = addr_q;
  assign ram_data    = data_q;
  assign busy        = (state_q != ST_IDLE);
  assign error       = error_q;

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - scoreboard bench for ram_loader with the RAM attached
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_write;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] rd_addr;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  ram_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_write  (ram_write),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  _RAM_32bit_16aline u_ram (
    .clk    (clk),
    .wr_addr(ram_address),
    .wr_data(ram_data),
    .wr_en  (ram_write),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] model[bit [15:0]];
  logic [31:0] wq[$];
  int          gap_q[$];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  int          last_wr_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      chk("wr_during_reset", ram_write, 1'b0);
    end else begin
      chk("in_ready_vs_write_done", in_ready, !(ram_write || done));
      if (ram_write) begin
        wr_cnt++;
        gap_q.push_back(cyc - last_wr_cyc);
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", ram_address, e.a);
          chk("wr_data", ram_data, e.d);
        end
      end
      if (done)  done_cnt++;
      if (error) err_cnt++;
    end
  end

  function automatic int rb(input int m);
    return (m == 0) ? 0 : int'($urandom_range(0, m));
  endfunction

  task automatic push_word(input logic [15:0] a, input logic [31:0] d);
    exp_q.push_back('{a: a, d: d});
    model[a] = d;
  endtask

  task automatic send(input logic [7:0] b, input int bub);
    logic ok;
    in_valid = 1'b0;
    repeat (bub) begin
      @(posedge clk);
      #1;
    end
    in_byte  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic load(input logic [15:0] a, input int maxbub);
    logic [15:0] n;
    n = 16'(wq.size());
    send(8'hA5, rb(maxbub));
    send(a[7:0], rb(maxbub));
    send(a[15:8], rb(maxbub));
    send(n[7:0], rb(maxbub));
    send(n[15:8], rb(maxbub));
    for (int i = 0; i < wq.size(); i++) begin
      logic [31:0] w;
      w = wq[i];
      push_word(a + 16'(i), w);
      for (int k = 0; k < 4; k++) send(w[8*k +: 8], rb(maxbub));
    end
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 200 && done_cnt < target; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("done_count", done_cnt, target);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_ram_write"}, ram_write, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ram_address"}, ram_address, 16'h0);
    chk({tag, "_ram_data"}, ram_data, 32'h0);
  endtask

  initial begin
    int wr0;
    int dn0;
    int er0;
    reset    = 1'b1;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    rd_addr  = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle_outputs("reset");

    // Two words at 0x1000, continuous stream
    wq = '{32'h44332211, 32'h88776655};
    load(16'h1000, 0);
    wait_done(1);
    chk("two_word_writes", wr_cnt, 2);
    chk("throughput_gap", gap_q[gap_q.size()-1], 5);
    chk("busy_after_done", busy, 1'b0);

    // Address wrap 0xFFFF -> 0x0000
    wq = '{32'hDEADBEEF, 32'hCAFEF00D};
    load(16'hFFFF, 0);
    wait_done(2);
    chk("wrap_writes", wr_cnt, 4);

    // Zero count: done right after CNT1, no write
    wr0 = wr_cnt;
    send(8'hA5, 0);
    send(8'h34, 0);
    send(8'h12, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    chk("zero_done", done, 1'b1);
    chk("zero_busy_in_done", busy, 1'b1);
    chk("zero_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("zero_done_fall", done, 1'b0);
    chk("zero_busy_fall", busy, 1'b0);
    chk("zero_no_write", wr_cnt, wr0);
    chk("zero_done_count", done_cnt, 3);

    // Bad byte in IDLE, then a normal load
    er0 = err_cnt;
    send(8'h3C, 0);
    chk("error_pulse", error, 1'b1);
    chk("error_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    chk("error_fall", error, 1'b0);
    chk("error_count", err_cnt, er0 + 1);
    wq = '{32'h0BADF00D};
    load(16'h0500, 0);
    wait_done(4);

    // Reset in WRITE of the first of three words
    wr0 = wr_cnt;
    dn0 = done_cnt;
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h20, 0);
    send(8'h03, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 0);
    send(8'h04, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle_outputs("abort");
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_write", wr_cnt, wr0);
    chk("abort_no_done", done_cnt, dn0);
    wq = '{32'h01020304, 32'hA1B2C3D4};
    load(16'h2000, 0);
    wait_done(dn0 + 1);
    chk("after_abort_writes", wr_cnt, wr0 + 2);

    // Four words with random bubbles
    wq = '{};
    for (int i = 0; i < 4; i++) wq.push_back($urandom);
    load(16'h3F00, 3);
    wait_done(dn0 + 2);
    chk("bubble_writes", wr_cnt, wr0 + 6);

    // RAM readback against the model
    foreach (model[a]) begin
      rd_addr = a;
      #1;
      chk("ram_readback", rd_data, model[a]);
    end
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
